lvds_tx_mapper: RTL
===================

// Module: lvds_tx_mapper
// PURPOSE
//  Parametrised pixel-to-LVDS word mapper for 1..4 FPD-link channels. It sits between the
//  display timing source and the per-link serdes_4b_7to1_wrapper instances.
//  Maps RGB888 plus HS/VS/DE into 28-bit 4-lane words, with two runtime options:
//   - VESA or JEIDA bit order
//   - 18- or 24-bit colour depth
//  Also provides per-link enable, lane polarity inversion and a built-in colour-bar
//  generator. Config changes are applied only at a frame boundary.
// PARAMETERS
//  NUM_LINKS      2        number of LVDS links (1..4); link 0 = pixel MSBs
//  BAR_WIDTH      160      colour-bar width in clkin cycles (>=1)
//  CTRL_ALL_LINKS 0        1: HS/VS/DE on every link; 0: link 0 only, other links carry 0
//  LANE_INV_MASK  4*NUM_LINKS'b0  bit 4n+L=1 inverts all 7 bits of lane L of link n
// PORTS
//  clkin        in   1              pixel clock
//  rstin_n      in   1              reset, asynchronous, active-low
//  pix_data     in   24*NUM_LINKS   per link {R[7:0],G[7:0],B[7:0]}; link n at [24*(NUM_LINKS-n)-1 -: 24]
//  pix_de       in   1              data enable
//  pix_hs       in   1              hsync, passed through, no polarity change
//  pix_vs       in   1              vsync, passed through, no polarity change
//  cfg_jeida    in   1              0 VESA, 1 JEIDA
//  cfg_18bit    in   1              1 = 18-bit mode
//  cfg_tpg_en   in   1              1 = replace pixels with colour bars
//  cfg_link_en  in   NUM_LINKS      per-link enable
//  tx_word      out  28*NUM_LINKS   to serdes; link n at [28*(NUM_LINKS-n)-1 -: 28]
//  cfg_active   out  3+NUM_LINKS    applied {jeida,18bit,tpg,link_en}
//  frame_start  out  1              1-cycle pulse when a config load occurs
// BEHAVIOUR
//  - Reset values:
//    - all pipeline registers, tx_word, frame_start and TPG counters = 0
//    - cfg_active = {0,0,0,all ones}
//  - Pipeline: S1 registers pix_*, cfg_*. S2 applies TPG mux, mapping, inversion and
//    link mask. tx_word is valid 2 clkin cycles after input; data and syncs share the same
//    latency.
//  - Word format: slot s (0..6) of lane L is at tx_word bit 4*(6-s)+L.
//  - VESA slots 0..6:
//    - L0 = R0..R5,G0
//    - L1 = G1..G5,B0,B1
//    - L2 = B2..B5,HS,VS,DE
//    - L3 = R6,R7,G6,G7,B6,B7,0
//  - JEIDA slots 0..6:
//    - L0 = R2..R7,G2
//    - L1 = G3..G7,B2,B3
//    - L2 = B4..B7,HS,VS,DE
//    - L3 = R0,R1,G0,G1,B0,B1,0
//  - 18-bit mode: L0..L2 use the JEIDA assignment regardless of cfg_jeida (top 6 bits per
//    colour); L3 = 7'b0 before inversion.
//  - Config load: vs_rise = S1 vs=1 and previous S1 vs=0. On that cycle:
//    - cfg_active <= S1 cfg
//    - frame_start <= 1
//    - the S2 word computed in the same cycle already uses the S1 cfg, i.e. the first
//      vs=1 word uses the new config
//  - cfg inputs changing mid-frame: no effect until the next vs_rise.
//  - Link disabled: its 28 bits = 0, after inversion (inverted lanes therefore emit 1s).
//  - TPG:
//    - bar_cnt 0..BAR_WIDTH-1 and bar_idx 0..7 advance on S1 de=1.
//    - bar_cnt wraps to 0 and increments bar_idx, which saturates at 7.
//    - Both counters clear on any S1 de=0 cycle.
//    - Colours, idx 0..7: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
//    - All links get the same bar colour; syncs are unaffected.
//    - The word for the first de=1 pixel of a line is bar 0.
//  - Simultaneous vs_rise and de=1: the config is loaded and the TPG enable takes effect
//    on that word.
//  - Reset mid-frame: outputs go to 0 asynchronously. The first config load follows the
//    next vs_rise; the reset config is used until then.
// STRUCTURE
//  - lvds_tx_pkg:
//    - SLOTS=7, LANES=4, WORD_W=28
//    - VESA/JEIDA slot-index constant tables
//    - bar colour LUT function
//    - cfg struct/localparam offsets
//  - One sub-module, lvds_tx_link_map (combinational, 1 link):
//    - inputs: rgb, ctrl, mode, inv mask, enable
//    - output: 28-bit word
//    - generate-instantiated NUM_LINKS times; TPG and S1/S2 registers stay in the top.
// TESTING
//  - VESA, 24-bit, NUM_LINKS=2:
//    - link0 rgb=0x010000 (R0=1), hs=vs=de=0 -> link0 tx_word = 28'h1000000 after 2 clks
//    - link1 = 0
//  - de=1 alone -> link0 bit 2 = 1. With CTRL_ALL_LINKS=0, link1 bit 2 = 0; with 1, = 1.
//  - Set cfg_jeida=1 mid-frame with rgb R=0x04:
//    - words stay VESA (bit 16) until vs rises
//    - on the vs=1 word and after, output is JEIDA (bit 24)
//    - frame_start pulses once
//  - 18-bit mode, rgb=FFFFFF -> lane3 bits (3,7,..,27) = 0, all 18 colour bits of L0..L2 = 1.
//  - TPG, BAR_WIDTH=4, de high 40 clks:
//    - 4 words white, 4 yellow, ... bar 7 black
//    - remains black until de=0; next line restarts white
//  - cfg_link_en=2'b10 after vs_rise, LANE_INV_MASK bit0=1:
//    - link0 word = 28'h1111111
//    - link1 carries pixel data
//  - Async reset mid-line -> tx_word=0, cfg_active=reset value; recovery on next vs_rise.

Source files
------------

// File: rtl/lvds_tx_pkg.sv
// ---------------------------------------------------------------------------
// lvds_tx_pkg: shared constants, slot tables and colour-bar LUT, rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lvds_tx_pkg;

  localparam int SLOTS  = 7;
  localparam int LANES  = 4;
  localparam int WORD_W = 28;

  // Source vector index map: 0..7 R, 8..15 G, 16..23 B, 24 HS, 25 VS, 26 DE, 27 constant 0
  typedef logic [4:0] src_idx_t;

  localparam src_idx_t VESA_TBL [LANES][SLOTS] = '{
    '{5'd0,  5'd1,  5'd2,  5'd3,  5'd4,  5'd5,  5'd8 },
    '{5'd9,  5'd10, 5'd11, 5'd12, 5'd13, 5'd16, 5'd17},
    '{5'd18, 5'd19, 5'd20, 5'd21, 5'd24, 5'd25, 5'd26},
    '{5'd6,  5'd7,  5'd14, 5'd15, 5'd22, 5'd23, 5'd27}
  };

  localparam src_idx_t JEIDA_TBL [LANES][SLOTS] = '{
    '{5'd2,  5'd3,  5'd4,  5'd5,  5'd6,  5'd7,  5'd10},
    '{5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd18, 5'd19},
    '{5'd20, 5'd21, 5'd22, 5'd23, 5'd24, 5'd25, 5'd26},
    '{5'd0,  5'd1,  5'd8,  5'd9,  5'd16, 5'd17, 5'd27}
  };

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } ctrl_t;

  // Field order matches the top bits of cfg_active: {jeida, 18bit, tpg}
  typedef struct packed {
    logic jeida;
    logic b18;
    logic tpg;
  } cfg_mode_t;

  localparam int CFG_MODE_W = 3;

  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = 24'hFFFFFF;
      3'd1:    bar_color = 24'hFFFF00;
      3'd2:    bar_color = 24'h00FFFF;
      3'd3:    bar_color = 24'h00FF00;
      3'd4:    bar_color = 24'hFF00FF;
      3'd5:    bar_color = 24'hFF0000;
      3'd6:    bar_color = 24'h0000FF;
      default: bar_color = 24'h000000;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lvds_tx_mapper_if.sv
// ---------------------------------------------------------------------------
// lvds_tx_mapper_if: pixel/config in, LVDS words and status out, rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface lvds_tx_mapper_if
  import lvds_tx_pkg::*;
#(
  parameter int NUM_LINKS = 2
);
  logic [24*NUM_LINKS-1:0]     pix_data;
  logic                        pix_de;
  logic                        pix_hs;
  logic                        pix_vs;
  logic                        cfg_jeida;
  logic                        cfg_18bit;
  logic                        cfg_tpg_en;
  logic [NUM_LINKS-1:0]        cfg_link_en;
  logic [WORD_W*NUM_LINKS-1:0] tx_word;
  logic [CFG_MODE_W+NUM_LINKS-1:0] cfg_active;
  logic                        frame_start;

  modport master (
    output pix_data, pix_de, pix_hs, pix_vs,
    output cfg_jeida, cfg_18bit, cfg_tpg_en, cfg_link_en,
    input  tx_word, cfg_active, frame_start
  );

  modport slave (
    input  pix_data, pix_de, pix_hs, pix_vs,
    input  cfg_jeida, cfg_18bit, cfg_tpg_en, cfg_link_en,
    output tx_word, cfg_active, frame_start
  );
endinterface

`default_nettype wire

// File: rtl/lvds_tx_link_map.sv
// ---------------------------------------------------------------------------
// lvds_tx_link_map: combinational RGB+sync to 28-bit word for one link, rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lvds_tx_link_map
  import lvds_tx_pkg::*;
(
  input  logic [23:0]       i_rgb,
  input  ctrl_t             i_ctrl,
  input  logic              i_jeida,
  input  logic              i_18bit,
  input  logic [LANES-1:0]  i_inv,
  input  logic              i_en,
  output logic [WORD_W-1:0] o_word
);

  logic [31:0] w_src;
  logic        w_use_jeida;

  assign w_src = {5'b0, i_ctrl.de, i_ctrl.vs, i_ctrl.hs,
                  i_rgb[7:0], i_rgb[15:8], i_rgb[23:16]};

  // 18-bit mode carries the top six bits of each colour, which is the JEIDA order
  assign w_use_jeida = i_jeida | i_18bit;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    localparam bit IS_L3 = (l == LANES - 1);
    for (genvar s = 0; s < SLOTS; s++) begin : g_slot
      src_idx_t w_idx;
      logic     w_bit;
      assign w_idx = w_use_jeida ? JEIDA_TBL[l][s] : VESA_TBL[l][s];
      assign w_bit = i_en & ~(i_18bit & IS_L3) & w_src[w_idx];
      assign o_word[4*(SLOTS-1-s)+l] = w_bit ^ i_inv[l];
    end
  end

endmodule

`default_nettype wire

// File: rtl/lvds_tx_mapper.sv
// ---------------------------------------------------------------------------
// lvds_tx_mapper: 2-stage pixel to FPD-link word mapper with colour bars, rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lvds_tx_mapper
  import lvds_tx_pkg::*;
#(
  parameter int                     NUM_LINKS      = 2,
  parameter int                     BAR_WIDTH      = 160,
  parameter int                     CTRL_ALL_LINKS = 0,
  parameter logic [4*NUM_LINKS-1:0] LANE_INV_MASK  = '0
)
(
  input  logic             clkin,
  input  logic             rstin_n,
  lvds_tx_mapper_if.slave  bus
);

  localparam int              CNT_W    = (BAR_WIDTH > 1) ? $clog2(BAR_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAR_WIDTH - 1);

  logic [24*NUM_LINKS-1:0]     r_s1_pix;
  ctrl_t                       r_s1_ctrl;
  cfg_mode_t                   r_s1_mode;
  logic [NUM_LINKS-1:0]        r_s1_link_en;
  logic                        r_s1_vs_d;
  cfg_mode_t                   r_act_mode;
  logic [NUM_LINKS-1:0]        r_act_link_en;
  logic [CNT_W-1:0]            r_bar_cnt;
  logic [2:0]                  r_bar_idx;
  logic [WORD_W*NUM_LINKS-1:0] r_tx_word;
  logic                        r_frame_start;

  logic                        w_vs_rise;
  cfg_mode_t                   w_mode;
  logic [NUM_LINKS-1:0]        w_link_en;
  logic [23:0]                 w_bar_rgb;
  logic [WORD_W*NUM_LINKS-1:0] w_tx_word;

  // The word leaving S2 on a vs rise already uses the config being loaded
  assign w_vs_rise = r_s1_ctrl.vs & ~r_s1_vs_d;
  assign w_mode    = w_vs_rise ? r_s1_mode    : r_act_mode;
  assign w_link_en = w_vs_rise ? r_s1_link_en : r_act_link_en;
  assign w_bar_rgb = bar_color(r_bar_idx);

  always_ff @(posedge clkin or negedge rstin_n) begin
    if (!rstin_n) begin
      r_s1_pix     <= '0;
      r_s1_ctrl    <= '0;
      r_s1_mode    <= '0;
      r_s1_link_en <= '0;
      r_s1_vs_d    <= 1'b0;
    end else begin
      r_s1_pix     <= bus.pix_data;
      r_s1_ctrl    <= {bus.pix_hs, bus.pix_vs, bus.pix_de};
      r_s1_mode    <= {bus.cfg_jeida, bus.cfg_18bit, bus.cfg_tpg_en};
      r_s1_link_en <= bus.cfg_link_en;
      r_s1_vs_d    <= r_s1_ctrl.vs;
    end
  end

  always_ff @(posedge clkin or negedge rstin_n) begin
    if (!rstin_n) begin
      r_act_mode    <= '0;
      r_act_link_en <= '1;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_vs_rise;
      if (w_vs_rise) begin
        r_act_mode    <= r_s1_mode;
        r_act_link_en <= r_s1_link_en;
      end
    end
  end

  // Counters hold the bar of the pixel currently in S1, so the first active pixel is bar 0
  always_ff @(posedge clkin or negedge rstin_n) begin
    if (!rstin_n) begin
      r_bar_cnt <= '0;
      r_bar_idx <= '0;
    end else if (!r_s1_ctrl.de) begin
      r_bar_cnt <= '0;
      r_bar_idx <= '0;
    end else if (r_bar_cnt == CNT_LAST) begin
      r_bar_cnt <= '0;
      if (r_bar_idx != 3'd7) begin
        r_bar_idx <= r_bar_idx + 3'd1;
      end
    end else begin
      r_bar_cnt <= r_bar_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clkin or negedge rstin_n) begin
    if (!rstin_n) begin
      r_tx_word <= '0;
    end else begin
      r_tx_word <= w_tx_word;
    end
  end

  for (genvar n = 0; n < NUM_LINKS; n++) begin : g_link
    localparam int PIX_HI  = 24 * (NUM_LINKS - n) - 1;
    localparam int WORD_HI = WORD_W * (NUM_LINKS - n) - 1;

    logic [23:0] w_rgb;
    ctrl_t       w_ctrl;

    assign w_rgb = w_mode.tpg ? w_bar_rgb : r_s1_pix[PIX_HI -: 24];

    if (CTRL_ALL_LINKS != 0 || n == 0) begin : g_ctrl
      assign w_ctrl = r_s1_ctrl;
    end else begin : g_no_ctrl
      assign w_ctrl = '0;
    end

    lvds_tx_link_map u_map (
      .i_rgb   (w_rgb),
      .i_ctrl  (w_ctrl),
      .i_jeida (w_mode.jeida),
      .i_18bit (w_mode.b18),
      .i_inv   (LANE_INV_MASK[4*n +: 4]),
      .i_en    (w_link_en[n]),
      .o_word  (w_tx_word[WORD_HI -: WORD_W])
    );
  end

  assign bus.tx_word     = r_tx_word;
  assign bus.cfg_active  = {r_act_mode, r_act_link_en};
  assign bus.frame_start = r_frame_start;

endmodule

`default_nettype wire
